// File: rtl/fe_frombytes_stream_pkg.sv
// Shared constants, tables and FSM state type for the ed25519 field-element
// byte loader: limb geometry, ref10 unpack offsets/shifts and carry order.
package fe_frombytes_stream_pkg;

    localparam int FE_NLIMBS = 10;
    localparam int FE_LIMB_W = 32;
    localparam int FE_BYTES  = 32;
    localparam int CARRY_STEPS = 10;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_UNPACK,
        ST_CARRY,
        ST_DONE
    } fe_state_e;

    // Even limbs hold 26 bits, odd limbs 25 bits (radix 2^25.5).
    function automatic int limb_bits(input int i);
        return (i % 2 == 0) ? 26 : 25;
    endfunction

    // Byte offset of the little-endian load feeding limb i.
    function automatic int unpack_off(input int i);
        case (i)
            0:       return 0;
            1:       return 4;
            2:       return 7;
            3:       return 10;
            4:       return 13;
            5:       return 16;
            6:       return 20;
            7:       return 23;
            8:       return 26;
            default: return 29;
        endcase
    endfunction

    // Left shift applied to the load of limb i.
    function automatic int unpack_shl(input int i);
        case (i)
            0:       return 0;
            1:       return 6;
            2:       return 5;
            3:       return 3;
            4:       return 2;
            5:       return 0;
            6:       return 7;
            7:       return 5;
            8:       return 4;
            default: return 2;
        endcase
    endfunction

    // Limbs 0 and 5 use a 4-byte load, all others a 3-byte load.
    function automatic bit unpack_ld4(input int i);
        return (i == 0) || (i == 5);
    endfunction

    // Limb carried at step k: 9,1,3,5,7,0,2,4,6,8.
    function automatic logic [3:0] carry_limb(input logic [3:0] k);
        case (k)
            4'd0:    return 4'd9;
            4'd1:    return 4'd1;
            4'd2:    return 4'd3;
            4'd3:    return 4'd5;
            4'd4:    return 4'd7;
            4'd5:    return 4'd0;
            4'd6:    return 4'd2;
            4'd7:    return 4'd4;
            4'd8:    return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/fe_frombytes_stream_unpack.sv
// Combinational ref10 unpack: 32 little-endian bytes -> 10 pre-carry limbs.
// Ports: s_vec (byte j at bits 8j+7:8j), h[0..9] zero-extended ACC_W limbs.
module fe_frombytes_stream_unpack
    import fe_frombytes_stream_pkg::*;
#(
    parameter int ACC_W    = 40,
    parameter bit MASK_TOP = 1'b1
) (
    input  logic [8*FE_BYTES-1:0]   s_vec,
    output logic signed [ACC_W-1:0] h [FE_NLIMBS]
);

    // Bit 255 sits at bit 23 of the last 3-byte load.
    localparam logic [23:0] TOP_MASK = MASK_TOP ? 24'h7FFFFF : 24'hFFFFFF;

    for (genvar i = 0; i < FE_NLIMBS; i++) begin : g_limb
        localparam int OFF = unpack_off(i);
        localparam int SHL = unpack_shl(i);
        logic [31:0] raw;

        if (unpack_ld4(i)) begin : g_ld4
            assign raw = s_vec[8*OFF +: 32];
        end else if (i == FE_NLIMBS - 1) begin : g_top
            assign raw = {8'd0, s_vec[8*OFF +: 24] & TOP_MASK};
        end else begin : g_ld3
            assign raw = {8'd0, s_vec[8*OFF +: 24]};
        end

        assign h[i] = $signed({{(ACC_W-32){1'b0}}, raw} << SHL);
    end

endmodule

// File: rtl/fe_frombytes_stream.sv
// Byte-serial ed25519 field-element loader: collects 32 bytes, unpacks into
// 10 signed limbs, runs the ref10 carry chain one carry per clock.
// Ports: clk; rst (sync, active low); in_byte/in_valid/in_ready byte input;
// out = limbs h0..h9 (h_i at out[LIMB_W*i +: LIMB_W]); done = 1-cycle pulse.
module fe_frombytes_stream
    import fe_frombytes_stream_pkg::*;
#(
    parameter int LIMB_W   = FE_LIMB_W,
    parameter int ACC_W    = 40,
    parameter bit MASK_TOP = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_byte,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [FE_NLIMBS*LIMB_W-1:0]   out,
    output logic                          done
);

    localparam int SR_W   = 8 * FE_BYTES;
    localparam int CNT_W  = $clog2(FE_BYTES);
    localparam int ODD_W  = limb_bits(1);
    localparam int EVEN_W = limb_bits(0);
    localparam logic signed [ACC_W-1:0] ONE = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] RND_ODD  = ONE <<< (ODD_W - 1);
    localparam logic signed [ACC_W-1:0] RND_EVEN = ONE <<< (EVEN_W - 1);

    fe_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [3:0]                   step_q, step_d;
    logic [SR_W-1:0]              sr_q, sr_d;
    logic signed [ACC_W-1:0]      h_q [FE_NLIMBS];
    logic signed [ACC_W-1:0]      h_d [FE_NLIMBS];
    logic [FE_NLIMBS*LIMB_W-1:0]  out_q, out_d;
    logic                         done_q, done_d;

    logic signed [ACC_W-1:0]      unp [FE_NLIMBS];

    logic [3:0]                   idx;
    logic [3:0]                   dst;
    logic signed [ACC_W-1:0]      cur;
    logic signed [ACC_W-1:0]      c;
    logic signed [ACC_W-1:0]      rem;
    logic signed [ACC_W-1:0]      add;

    fe_frombytes_stream_unpack #(
        .ACC_W    (ACC_W),
        .MASK_TOP (MASK_TOP)
    ) u_unpack (
        .s_vec (sr_q),
        .h     (unp)
    );

    // Shared carry datapath, steered by the current step.
    always_comb begin
        idx = carry_limb(step_q);
        dst = (idx == 4'd9) ? 4'd0 : idx + 4'd1;
        cur = h_q[idx];
        if (idx[0]) begin
            c   = (cur + RND_ODD) >>> ODD_W;
            rem = cur - (c <<< ODD_W);
        end else begin
            c   = (cur + RND_EVEN) >>> EVEN_W;
            rem = cur - (c <<< EVEN_W);
        end
        // Wrap from h9 to h0 folds 2^255 = 19 mod p.
        add = (idx == 4'd9) ? (c <<< 4) + (c <<< 1) + c : c;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        sr_d    = sr_q;
        h_d     = h_q;
        out_d   = out_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    // New bytes enter at the top so s[0] ends at bits 7:0.
                    sr_d  = {in_byte, sr_q[SR_W-1:8]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FE_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_UNPACK;
                    end
                end
            end
            ST_UNPACK: begin
                h_d     = unp;
                step_d  = '0;
                state_d = ST_CARRY;
            end
            ST_CARRY: begin
                h_d[idx] = rem;
                h_d[dst] = h_q[dst] + add;
                step_d   = step_q + 4'd1;
                if (step_q == 4'(CARRY_STEPS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                for (int i = 0; i < FE_NLIMBS; i++) begin
                    out_d[LIMB_W*i +: LIMB_W] = h_q[i][LIMB_W-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            step_q  <= '0;
            sr_q    <= '0;
            h_q     <= '{default: '0};
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            sr_q    <= sr_d;
            h_q     <= h_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == ST_LOAD);
    assign out      = out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_fe_frombytes_stream.sv
// Bench for fe_frombytes_stream: directed and random elements checked
// against a ref10-style arithmetic model, plus reset-abort scenarios.
module tb_fe_frombytes_stream;

    typedef logic [7:0] bytes_t [32];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_byte = 8'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [319:0] out;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fe_frombytes_stream dut (
        .clk      (clk),
        .rst      (rst_n),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .done     (done)
    );

    function automatic longint ld3(input bytes_t s, input int o);
        longint v;
        v = {40'd0, s[o+2], s[o+1], s[o]};
        return v;
    endfunction

    function automatic longint ld4(input bytes_t s, input int o);
        longint v;
        v = {32'd0, s[o+3], s[o+2], s[o+1], s[o]};
        return v;
    endfunction

    // ref10 fe_frombytes in plain 64-bit arithmetic.
    function automatic logic [319:0] ref_model(input bytes_t s);
        longint h [10];
        longint c;
        logic [319:0] r;
        h[0] = ld4(s, 0);
        h[1] = ld3(s, 4) << 6;
        h[2] = ld3(s, 7) << 5;
        h[3] = ld3(s, 10) << 3;
        h[4] = ld3(s, 13) << 2;
        h[5] = ld4(s, 16);
        h[6] = ld3(s, 20) << 7;
        h[7] = ld3(s, 23) << 5;
        h[8] = ld3(s, 26) << 4;
        h[9] = (ld3(s, 29) & 64'sh7FFFFF) << 2;
        c = (h[9] + (64'sd1 <<< 24)) >>> 25;
        h[0] += c * 19;
        h[9] -= c <<< 25;
        for (int i = 1; i < 9; i += 2) begin
            c = (h[i] + (64'sd1 <<< 24)) >>> 25;
            h[i+1] += c;
            h[i] -= c <<< 25;
        end
        for (int i = 0; i < 10; i += 2) begin
            c = (h[i] + (64'sd1 <<< 25)) >>> 26;
            h[i+1] += c;
            h[i] -= c <<< 26;
        end
        for (int i = 0; i < 10; i++) begin
            r[32*i +: 32] = h[i][31:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs,
                       input logic [319:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive bytes 0..n-1; called and returns at a negedge.
    task automatic send_bytes(input bytes_t b, input int n,
                              input int gap_max, input bit preloaded);
        bit acc;
        int tries;
        for (int j = 0; j < n; j++) begin
            if (gap_max > 0 && !(j == 0 && preloaded)) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    in_valid = 1'b0;
                    in_byte  = 8'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_byte  = b[j];
            tries = 0;
            do begin
                acc = in_ready;
                @(posedge clk);
                @(negedge clk);
                tries++;
            end while (!acc && tries < 50);
            if (!acc) begin
                vectors++;
                miscompares++;
                $error("FAIL accept_timeout byte=%0d observed=0 expected=1", j);
            end
        end
    endtask

    task automatic send_element(input string name, input bytes_t b,
                                input logic [319:0] exp, input int gap_max,
                                input bit has_next, input logic [7:0] nb0,
                                input bit preloaded);
        logic [319:0] held;
        int lat;
        bit got;
        send_bytes(b, 32, gap_max, preloaded);
        // Next element's byte 0 is held while the block is busy.
        in_valid = has_next;
        in_byte  = has_next ? nb0 : 8'($urandom);
        held = out;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk({name, "_hold"}, out, held);
                chk({name, "_busy"}, 320'(in_ready), 320'd0);
            end
        end
        chk({name, "_latency"}, 320'(lat), 320'd12);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_h%0d", name, i), 320'(out[32*i +: 32]),
                320'(exp[32*i +: 32]));
        end
        chk({name, "_ready_at_done"}, 320'(in_ready), 320'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_rst_out"}, out, 320'd0);
        chk({name, "_rst_done"}, 320'(done), 320'd0);
        chk({name, "_rst_ready"}, 320'(in_ready), 320'd1);
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_no_done"}, 320'(done), 320'd0);
        end
    endtask

    bytes_t       b;
    bytes_t       rnd [8];
    logic [319:0] e;

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_out", out, 320'd0);
        chk("reset_done", 320'(done), 320'd0);
        chk("reset_ready", 320'(in_ready), 320'd1);

        b = '{default: 8'h00};
        send_element("zero", b, 320'd0, 0, 1'b0, 8'd0, 1'b0);

        b = '{default: 8'h00};
        b[0] = 8'h01;
        send_element("s0_1", b, 320'd1, 2, 1'b0, 8'd0, 1'b0);

        b = '{default: 8'h00};
        b[3] = 8'h04;
        e = 320'd1 << 32;
        send_element("s3_4", b, e, 0, 1'b0, 8'd0, 1'b0);

        b = '{default: 8'h00};
        b[3] = 8'h02;
        e = (320'd1 << 32) | 320'hFE000000;
        send_element("s3_2", b, e, 1, 1'b0, 8'd0, 1'b0);

        b = '{default: 8'h00};
        b[31] = 8'h80;
        send_element("top_bit", b, 320'd0, 0, 1'b0, 8'd0, 1'b0);

        b = '{default: 8'hFF};
        send_element("all_ff", b, ref_model(b), 0, 1'b0, 8'd0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 32; j++) begin
                rnd[k][j] = 8'($urandom);
            end
        end
        for (int k = 0; k < 8; k++) begin
            send_element($sformatf("rnd%0d", k), rnd[k], ref_model(rnd[k]),
                         (k % 2 == 0) ? 3 : 0, k < 7, rnd[(k + 1) % 8][0],
                         k > 0);
        end
        e = out;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_width", 320'(done), 320'd0);
        chk("out_after_done", out, e);

        // Reset while byte 17 is presented.
        for (int j = 0; j < 32; j++) b[j] = 8'($urandom);
        send_bytes(b, 17, 1, 1'b0);
        in_valid = 1'b1;
        in_byte  = b[17];
        pulse_reset();
        check_quiet("rst_load");
        for (int j = 0; j < 32; j++) b[j] = 8'($urandom);
        send_element("after_rst_load", b, ref_model(b), 2, 1'b0, 8'd0, 1'b0);

        // Reset during carry step 4.
        for (int j = 0; j < 32; j++) b[j] = 8'($urandom);
        send_bytes(b, 32, 0, 1'b0);
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        pulse_reset();
        check_quiet("rst_carry");
        for (int j = 0; j < 32; j++) b[j] = 8'($urandom);
        send_element("after_rst_carry", b, ref_model(b), 0, 1'b0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
